// File: rtl/program_loader.sv
// program_loader: streams little-endian bytes into instruction memory as 32-bit words and holds the core in reset until a load completes.
// Define CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
`ifdef CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERR
   } state_t;
   state_t          state, state_n;
   logic [1:0]      bcnt;
   logic [ADDR_W:0] nw, widx;
   logic [31:0]     word;
   logic            take, idle_like, start_ok, last;
`ifdef CHECKSUM_EN
   logic [7:0]      xsum;
`endif
   assign take      = byte_valid && byte_ready;
   assign idle_like = state == IDLE || state == DONE || state == ERR;
   assign start_ok  = num_words != '0 && num_words <= CAP;
   // widx is one bit wider than the address so a full 2^ADDR_W load is detected without wrapping
   assign last      = widx + 1'b1 == nw;
   always_comb begin
      state_n  = state;
`ifdef CHECKSUM_EN
      byte_ready = state == RECV || state == CHECK;
      busy       = state == RECV || state == WRITE || state == CHECK;
`else
      byte_ready = state == RECV;
      busy       = state == RECV || state == WRITE;
`endif
      imem_we  = state == WRITE;
      done     = state == DONE;
      error    = state == ERR;
      core_rst = state != DONE;
      if (idle_like && start)
         state_n = start_ok ? RECV : ERR;
      else
         case (state)
            RECV:    if (take && bcnt == 2'd3) state_n = WRITE;
`ifdef CHECKSUM_EN
            WRITE:   state_n = last ? CHECK : RECV;
            CHECK:   if (take) state_n = byte_data == xsum ? DONE : ERR;
`else
            WRITE:   state_n = last ? DONE : RECV;
`endif
            default: ;
         endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bcnt       <= '0;
         nw         <= '0;
         widx       <= '0;
         word       <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
`ifdef CHECKSUM_EN
         xsum       <= '0;
`endif
      end else begin
         state <= state_n;
         if (idle_like && start && start_ok) begin
            nw   <= num_words;
            bcnt <= '0;
            widx <= '0;
`ifdef CHECKSUM_EN
            xsum <= '0;
`endif
         end
         // bytes shift in from the top so byte 0 lands in bits [7:0] after four transfers
         if (state == RECV && take) begin
            bcnt <= bcnt + 1'b1;
            word <= {byte_data, word[31:8]};
`ifdef CHECKSUM_EN
            xsum <= xsum ^ byte_data;
`endif
            if (bcnt == 2'd3) begin
               imem_addr  <= widx[ADDR_W-1:0];
               imem_wdata <= {byte_data, word[31:8]};
            end
         end
         if (state == WRITE) widx <= widx + 1'b1;
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed self-checking bench for program_loader against a byte-list reference model.
module tb_program_loader;
   localparam int AW = 8;
   logic          clk = 0;
   logic          rst = 1;
   logic          start = 0;
   logic [AW:0]   num_words = '0;
   logic          byte_valid = 0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready, imem_we, core_rst, busy, done, error;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   int            tests = 0, fails = 0, cyc = 0;
   logic [7:0]    bq[$];
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   int            wc_q[$], acc_q[$];

   program_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_words(num_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (byte_valid && byte_ready) acc_q.push_back(cyc);
      if (imem_we) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
         wc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
   endtask

   task automatic start_load(input int n);
      @(posedge clk); #1;
      start = 1; num_words = n[AW:0];
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_data = b; byte_valid = 1;
      @(negedge clk);
      while (!byte_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
         tests++; fails++;
         $display("FAIL send_byte: byte_ready never rose, got 0 required 1");
      end
      @(posedge clk); #1;
      byte_valid = 0;
   endtask

   task automatic drive_bytes(input int gap_mode, input logic [7:0] trailer);
      for (int i = 0; i < bq.size(); i++) begin
         int g;
         g = gap_mode == 0 ? 0 : gap_mode == 1 ? 2 : int'($urandom_range(0, 3));
         repeat (g) begin @(posedge clk); #1; end
         send_byte(bq[i]);
      end
`ifdef CHECKSUM_EN
      send_byte(trailer);
`else
      if (trailer != 8'h00) byte_data = 8'h00;
`endif
   endtask

   task automatic wait_end();
      int t = 0;
      @(negedge clk);
      while (!(done || error) && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
         tests++; fails++;
         $display("FAIL wait_end: no done/error within budget, got 0 required 1");
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      clear_log();
      @(negedge clk);
      tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b required 1", core_rst); end
      tests++; if ({done, error, busy, byte_ready, imem_we} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b required 00000", {done, error, busy, byte_ready, imem_we}); end
      tests++; if (imem_addr !== '0 || imem_wdata !== '0) begin fails++; $display("FAIL reset_bus: got %h/%h required 0/0", imem_addr, imem_wdata); end
      byte_valid = 1; byte_data = 8'hA5;
      repeat (5) @(posedge clk);
      #1 byte_valid = 0;
      @(negedge clk);
      tests++; if (acc_q.size() != 0 || wa_q.size() != 0) begin fails++; $display("FAIL idle_ignores_bytes: got %0d accepts %0d writes required 0", acc_q.size(), wa_q.size()); end
   endtask

   task automatic test_load(input string name, input int gap_mode);
      int n;
      logic [7:0] x;
      n = bq.size() / 4;
      x = 8'h00;
      foreach (bq[i]) x ^= bq[i];
      clear_log();
      start_load(n);
      drive_bytes(gap_mode, x);
      wait_end();
      tests++; if (wa_q.size() != n) begin fails++; $display("FAIL %s_wcount: got %0d required %0d", name, wa_q.size(), n); end
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         logic [31:0] exp;
         exp = bq[4*i] + (bq[4*i+1] * 256) + (bq[4*i+2] * 65536) + (bq[4*i+3] * 16777216);
         tests++; if (wa_q[i] !== i[AW-1:0]) begin fails++; $display("FAIL %s_addr%0d: got %0d required %0d", name, i, wa_q[i], i); end
         tests++; if (wd_q[i] !== exp) begin fails++; $display("FAIL %s_data%0d: got %h required %h", name, i, wd_q[i], exp); end
         tests++; if (acc_q.size() <= 4*i+3 || wc_q[i] != acc_q[4*i+3] + 1) begin fails++; $display("FAIL %s_latency%0d: got write cycle %0d, 4th byte cycle %0d", name, i, wc_q[i], acc_q.size() > 4*i+3 ? acc_q[4*i+3] : -1); end
      end
`ifdef CHECKSUM_EN
      tests++; if (acc_q.size() != 4*n + 1) begin fails++; $display("FAIL %s_accepts: got %0d required %0d", name, acc_q.size(), 4*n + 1); end
`else
      tests++; if (acc_q.size() != 4*n) begin fails++; $display("FAIL %s_accepts: got %0d required %0d", name, acc_q.size(), 4*n); end
`endif
      tests++; if ({done, error, core_rst, busy, byte_ready} !== 5'b10000) begin fails++; $display("FAIL %s_final: got done,error,core_rst,busy,ready=%b required 10000", name, {done, error, core_rst, busy, byte_ready}); end
   endtask

   task automatic test_directed();
      bq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
      test_load("b2b", 0);
      tests++; if (wd_q.size() < 2 || wd_q[0] !== 32'h00100093 || wd_q[1] !== 32'h00200113) begin fails++; $display("FAIL b2b_const: got %h %h required 00100093 00200113", wd_q.size() > 0 ? wd_q[0] : 32'hx, wd_q.size() > 1 ? wd_q[1] : 32'hx); end
      test_load("gapped", 1);
      tests++; if (wd_q.size() < 2 || wd_q[0] !== 32'h00100093 || wd_q[1] !== 32'h00200113) begin fails++; $display("FAIL gapped_const: got %h %h required 00100093 00200113", wd_q.size() > 0 ? wd_q[0] : 32'hx, wd_q.size() > 1 ? wd_q[1] : 32'hx); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         bq.delete();
         repeat (4 * $urandom_range(1, 6)) bq.push_back(8'($urandom));
         test_load("random", 2);
      end
      bq.delete();
      repeat (4 * (1 << AW)) bq.push_back(8'($urandom));
      test_load("full", 0);
      tests++; if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== {AW{1'b1}}) begin fails++; $display("FAIL full_last_addr: got %0d required %0d", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 0, (1 << AW) - 1); end
   endtask

   task automatic test_errors();
      int bad[2] = '{0, (1 << AW) + 1};
      foreach (bad[j]) begin
         clear_log();
         start_load(bad[j]);
         repeat (3) @(negedge clk);
         tests++; if ({error, done, core_rst, busy} !== 4'b1010) begin fails++; $display("FAIL err_n%0d: got error,done,core_rst,busy=%b required 1010", bad[j], {error, done, core_rst, busy}); end
         tests++; if (wa_q.size() != 0) begin fails++; $display("FAIL err_n%0d_we: got %0d writes required 0", bad[j], wa_q.size()); end
      end
   endtask

   task automatic test_abort();
      bq.delete();
      repeat (12) bq.push_back(8'($urandom));
      clear_log();
      start_load(3);
      @(negedge clk);
      tests++; if ({core_rst, busy, error} !== 3'b110) begin fails++; $display("FAIL abort_started: got core_rst,busy,error=%b required 110", {core_rst, busy, error}); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send_byte(bq[i]);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      tests++; if ({core_rst, busy, byte_ready, done, error} !== 5'b10000) begin fails++; $display("FAIL abort_idle: got %b required 10000", {core_rst, busy, byte_ready, done, error}); end
      bq.delete();
      repeat (8) bq.push_back(8'($urandom));
      test_load("after_abort", 2);
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      bq = '{8'h13, 8'h05, 8'h00, 8'h00};
      test_load("csum_good", 0);
      clear_log();
      start_load(1);
      drive_bytes(0, 8'h17);
      wait_end();
      tests++; if ({error, done, core_rst} !== 3'b101) begin fails++; $display("FAIL csum_bad_flags: got error,done,core_rst=%b required 101", {error, done, core_rst}); end
      tests++; if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 32'h00000513) begin fails++; $display("FAIL csum_bad_write: got %0d writes, first %h required 1 write 00000513 @0", wa_q.size(), wd_q.size() > 0 ? wd_q[0] : 32'hx); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_errors();
      test_abort();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream of the processor top. Streams a program into instruction memory as bytes, then releases the core.
- Holds the core in reset while it assembles little-endian 32-bit words from a byte-wide valid/ready stream.
- Writes each word to consecutive instruction-memory word addresses starting at 0.
- Releases the core from reset only after a complete, valid load.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session; latches num_words.
- num_words  input  ADDR_W+1  number of 32-bit words to load; legal range 1..2^ADDR_W.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  program byte, least-significant byte of each word first.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  instruction-memory word address.
- imem_wdata  output  32  assembled instruction word.
- core_rst  output  1  reset to the processor; high while not successfully loaded.
- busy  output  1  load session in progress.
- done  output  1  last load completed successfully.
- error  output  1  last load failed.

Behaviour:
- Reset values:
  - core_rst=1; all other outputs 0.
  - State IDLE; byte counter, word counter and address all 0.
  - rst is sampled every cycle, so it aborts a session in any state and returns to these values.
- States: IDLE, RECV, WRITE, CHECK (only with the optional feature), DONE, ERR.
- IDLE/DONE/ERR on start:
  - num_words==0 or num_words>2^ADDR_W: go to ERR.
  - Otherwise: latch num_words, clear counters and address, set core_rst=1, go to RECV.
  - start in any other state is ignored.
- RECV:
  - byte_ready=1 and busy=1.
  - A byte transfers when byte_valid && byte_ready.
  - Byte k (k=0..3) goes to word bits [8k+7:8k].
  - On the 4th byte go to WRITE the next cycle; stall indefinitely while byte_valid=0.
- WRITE (exactly 1 cycle):
  - imem_we=1 with imem_addr = current word index and imem_wdata = assembled word; byte_ready=0.
  - Next cycle: increment address and word counter.
  - If more words remain, go to RECV. If this was the last word, go to DONE (or to CHECK when CHECKSUM_EN is defined).
- Write latency: imem_we asserts in the cycle after the 4th byte of a word is accepted.
- Address range: the highest address written is num_words-1; a full load of 2^ADDR_W words never wraps.
- DONE:
  - done=1, core_rst=0, busy=0, byte_ready=0; held until rst or start.
  - A new start re-asserts core_rst in the following cycle.
- ERR: error=1, core_rst=1, busy=0; held until rst or start.
- done and error are mutually exclusive and both clear on start.
- While not in RECV, bytes are never accepted; byte_valid is ignored.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK with byte_ready=1.
  - Accept exactly one trailer byte; compare it to the XOR of all program bytes accepted this session.
  - Match: go to DONE. Mismatch: go to ERR, with core_rst held at 1.
  - Memory contents are already written in either case.
  - The running XOR clears on start and on rst.
- Not defined: no CHECK state; no trailer byte is consumed; DONE follows the last WRITE directly.

Test Plan:
- Reset then idle → core_rst=1, done=0, error=0, byte_ready=0, imem_we=0; bytes offered in IDLE are not accepted.
- start with num_words=2, bytes 93,00,10,00,13,01,20,00 sent back-to-back:
  - imem_we at addr 0 with 0x00100093, then at addr 1 with 0x00200113.
  - Each write is one cycle after its 4th byte.
  - Then done=1 and core_rst=0.
- Same load with byte_valid toggled 1,0,0,1,… → identical writes, words and addresses; no byte is lost or duplicated.
- start with num_words=0, and separately with num_words=2^ADDR_W+1 → ERR, error=1, core_rst=1, no imem_we.
- rst asserted after 5 bytes of a 3-word load, then a new start → state IDLE with core_rst=1; the new load restarts at addr 0 with a fresh byte counter.
- CHECKSUM_EN defined, 1-word load of 13,05,00,00:
  - Trailer 0x16 → done=1.
  - Trailer 0x17 → error=1, core_rst=1; the word was still written at addr 0.
